// File: rtl/lcd_frame_writer_if.sv
// Bundle between the LCD frame writer and its client/driver side.
// The master drives the frame request and timer state. The slave (the writer) drives the character stream.
interface lcd_frame_writer_if;
  logic       start;
  logic [1:0] mode;
  logic [7:0] min_bcd;
  logic [7:0] sec_bcd;
  logic [7:0] rnd_bcd;
  logic [7:0] char_out;
  logic       char_we;
  logic [3:0] char_idx;
  logic       busy;
  logic       frame_done;

  modport master (
    output start, mode, min_bcd, sec_bcd, rnd_bcd,
    input  char_out, char_we, char_idx, busy, frame_done
  );

  modport slave (
    input  start, mode, min_bcd, sec_bcd, rnd_bcd,
    output char_out, char_we, char_idx, busy, frame_done
  );
endinterface

// File: rtl/lcd_frame_writer.sv
// Formats the fitness-timer state into a 16-char line "<LBL> MM:SS R<RR>  ".
// The line is streamed one ASCII char per fixed-length slot.
// Each slot opens with a long write-enable window, so a slow-clocked character driver can catch every char.
module lcd_frame_writer #(
  parameter int WE_CYCLES  = 66000,
  parameter int GAP_CYCLES = 262144,
  parameter int CNT_W      = 20
) (
  input  logic               clk,
  input  logic               rst,
  lcd_frame_writer_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SLOT, S_FIN} state_t;

  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] LP_WE   = CNT_W'(WE_CYCLES);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_idx;
  logic [7:0]       r_char;
  logic             r_pending;
  logic [1:0]       r_mode;
  logic [7:0]       r_min;
  logic [7:0]       r_sec;
  logic [7:0]       r_rnd;
  logic             w_wrap;
  logic             w_load;
  logic             w_adv;
  logic [3:0]       w_next_col;

  function automatic logic [7:0] f_digit(input logic [3:0] n);
    return (n <= 4'd9) ? (8'h30 + {4'h0, n}) : 8'h3F;
  endfunction

  function automatic logic [7:0] f_label(input logic [1:0] md, input logic [1:0] pos);
    logic [31:0] txt;
    case (md)
      2'd0:    txt = "IDLE";
      2'd1:    txt = "WORK";
      2'd2:    txt = "REST";
      default: txt = "DONE";
    endcase
    case (pos)
      2'd0:    return txt[31:24];
      2'd1:    return txt[23:16];
      2'd2:    return txt[15:8];
      default: return txt[7:0];
    endcase
  endfunction

  function automatic logic [7:0] f_char(input logic [3:0] col, input logic [1:0] md,
                                        input logic [7:0] mn, input logic [7:0] sc,
                                        input logic [7:0] rn);
    case (col)
      4'd0, 4'd1, 4'd2, 4'd3: return f_label(md, col[1:0]);
      4'd5:    return f_digit(mn[7:4]);
      4'd6:    return f_digit(mn[3:0]);
      4'd7:    return 8'h3A;
      4'd8:    return f_digit(sc[7:4]);
      4'd9:    return f_digit(sc[3:0]);
      4'd11:   return 8'h52;
      4'd12:   return f_digit(rn[7:4]);
      4'd13:   return f_digit(rn[3:0]);
      default: return 8'h20;
    endcase
  endfunction

  assign w_wrap     = (r_state == S_SLOT) && (r_cnt == LP_LAST);
  assign w_load     = (r_state == S_IDLE) && (w_next == S_LOAD);
  // A new char is latched when entering slot 0 and at every slot boundary except the last.
  assign w_adv      = (r_state == S_LOAD) || (w_wrap && (r_idx != 4'd15));
  assign w_next_col = (r_state == S_LOAD) ? 4'd0 : (r_idx + 4'd1);

  assign bus.char_out   = r_char;
  assign bus.char_idx   = r_idx;
  assign bus.char_we    = (r_state == S_SLOT) && (r_cnt < LP_WE);
  assign bus.busy       = (r_state == S_LOAD) || (r_state == S_SLOT);
  assign bus.frame_done = (r_state == S_FIN);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic: a frame runs LOAD, then 16 slots, then FIN.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start || r_pending) w_next = S_LOAD;
      S_LOAD:  w_next = S_SLOT;
      S_SLOT:  if (w_wrap && (r_idx == 4'd15)) w_next = S_FIN;
      default: w_next = S_IDLE;
    endcase
  end

  // Slot counter, column index, presented char and the collapsed pending request.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_idx     <= 4'd0;
      r_char    <= 8'h20;
      r_pending <= 1'b0;
    end else begin
      if (w_load)                                 r_pending <= 1'b0;
      else if ((r_state != S_IDLE) && bus.start)  r_pending <= 1'b1;

      if ((r_state == S_SLOT) && !w_wrap) r_cnt <= r_cnt + 1'b1;
      else                                r_cnt <= '0;

      if (w_load)                             r_idx <= 4'd0;
      else if (w_wrap && (r_idx != 4'd15))    r_idx <= r_idx + 4'd1;

      if (w_adv) r_char <= f_char(w_next_col, r_mode, r_min, r_sec, r_rnd);
    end
  end

  // Snapshot of the timer state, so input changes cannot disturb a frame in flight.
  always_ff @(posedge clk) begin
    if (w_load) begin
      r_mode <= bus.mode;
      r_min  <= bus.min_bcd;
      r_sec  <= bus.sec_bcd;
      r_rnd  <= bus.rnd_bcd;
    end
  end

endmodule

// File: tb/tb_lcd_frame_writer.sv
// Testbench for lcd_frame_writer with short slot timing.
module tb_lcd_frame_writer;
  localparam int WE        = 2;
  localparam int GAP       = 5;
  localparam int FRAME_LEN = 16 * GAP;

  typedef struct {
    logic [7:0] ch;
    logic       we;
    logic [3:0] idx;
    logic       busy;
    logic       done;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lcd_frame_writer_if bus();

  lcd_frame_writer #(.WE_CYCLES(WE), .GAP_CYCLES(GAP), .CNT_W(20)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  exp_t       q[$];
  int         tests = 0;
  int         fails = 0;
  int         cyc   = 0;
  int         n_done = 0;
  logic [7:0] cap[16];

  // Reference model state: a frame is an active flag plus the number of edges since its LOAD.
  bit         m_active = 1'b0;
  int         m_pos    = 0;
  bit         m_pend   = 1'b0;
  logic [7:0] m_line[16];
  logic [7:0] m_char   = 8'h20;
  logic [3:0] m_idx    = 4'd0;
  string      lbl[4]   = '{"IDLE", "WORK", "REST", "DONE"};

  function automatic logic [7:0] dig(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : 8'h3F;
  endfunction

  function automatic void build_line(input logic [1:0] md, input logic [7:0] mn,
                                     input logic [7:0] sc, input logic [7:0] rn);
    string l;
    l = lbl[md];
    for (int i = 0; i < 16; i++) m_line[i] = 8'h20;
    for (int i = 0; i < 4; i++) m_line[i] = l[i];
    m_line[5]  = dig(mn[7:4]);
    m_line[6]  = dig(mn[3:0]);
    m_line[7]  = ":";
    m_line[8]  = dig(sc[7:4]);
    m_line[9]  = dig(sc[3:0]);
    m_line[11] = "R";
    m_line[12] = dig(rn[7:4]);
    m_line[13] = dig(rn[3:0]);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, expv, $time);
    end
  endtask

  // Reference model: pushes the expected outputs for the cycle that follows each edge.
  initial begin : model
    exp_t e;
    int k;
    int off;
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        m_active = 1'b0;
        m_pend   = 1'b0;
        m_char   = 8'h20;
        m_idx    = 4'd0;
      end else if (m_active) begin
        if (bus.start) m_pend = 1'b1;
        m_pos++;
        if (m_pos == FRAME_LEN + 2) m_active = 1'b0;
      end else if (bus.start || m_pend) begin
        m_active = 1'b1;
        m_pos    = 0;
        m_pend   = 1'b0;
        m_idx    = 4'd0;
        build_line(bus.mode, bus.min_bcd, bus.sec_bcd, bus.rnd_bcd);
      end
      e.we   = 1'b0;
      e.busy = m_active && (m_pos <= FRAME_LEN);
      e.done = m_active && (m_pos == FRAME_LEN + 1);
      if (m_active && (m_pos >= 1) && (m_pos <= FRAME_LEN)) begin
        k      = (m_pos - 1) / GAP;
        off    = (m_pos - 1) % GAP;
        e.we   = (off < WE);
        m_idx  = 4'(k);
        m_char = m_line[k];
      end
      e.ch  = m_char;
      e.idx = m_idx;
      q.push_back(e);
    end
  end

  // Monitor: pops one expectation per cycle and compares it with the DUT shortly after the edge.
  initial begin : monitor
    exp_t e;
    logic prev_we;
    prev_we = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL scoreboard_empty at t=%0t", $time);
      end else begin
        e = q.pop_front();
        chk("char_out",   bus.char_out,   e.ch);
        chk("char_we",    bus.char_we,    e.we);
        chk("char_idx",   bus.char_idx,   e.idx);
        chk("busy",       bus.busy,       e.busy);
        chk("frame_done", bus.frame_done, e.done);
      end
      if (bus.char_we && !prev_we) cap[bus.char_idx] = bus.char_out;
      if (bus.frame_done) n_done++;
      prev_we = bus.char_we;
    end
  end

  task automatic set_in(input logic [1:0] md, input logic [7:0] mn,
                        input logic [7:0] sc, input logic [7:0] rn);
    bus.mode    = md;
    bus.min_bcd = mn;
    bus.sec_bcd = sc;
    bus.rnd_bcd = rn;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int c;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!bus.frame_done && (c < limit));
    if (!bus.frame_done) chk("frame_done_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_col(input logic [3:0] col, input bit need_we, input int limit);
    int c;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!((bus.char_idx == col) && bus.busy && (bus.char_we || !need_we)) && (c < limit));
    if (!((bus.char_idx == col) && bus.busy)) chk("wait_col_timeout", {28'd0, bus.char_idx}, {28'd0, col});
  endtask

  task automatic chk_line(input string s);
    for (int i = 0; i < 16; i++) chk($sformatf("line_col%0d", i), cap[i], s[i]);
  endtask

  initial begin : stim
    int t0;
    int d0;
    bus.start = 1'b0;
    set_in(2'd0, 8'h00, 8'h00, 8'h00);

    // Reset with random inputs, then idle with start low.
    repeat (3) begin
      @(negedge clk);
      bus.start = 1'($urandom);
      set_in(2'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    end
    @(negedge clk);
    rst = 1'b0;
    bus.start = 1'b0;
    repeat (20) @(negedge clk);
    chk("idle_busy", bus.busy, 1'b0);
    chk("idle_char", bus.char_out, 8'h20);

    // Basic frame with timing of frame_done.
    set_in(2'd1, 8'h03, 8'h25, 8'h02);
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    t0 = cyc;
    wait_done(200);
    chk("done_cycle", cyc, t0 + FRAME_LEN + 1);
    chk_line("WORK 03:25 R02  ");

    // Non-decimal nibbles map to '?'.
    set_in(2'd2, 8'hF0, 8'h3A, 8'h11);
    pulse_start();
    wait_done(200);
    chk_line("REST ?0:3? R11  ");

    // Several starts during a frame collapse into one extra frame using later inputs.
    repeat (5) @(negedge clk);
    d0 = n_done;
    set_in(2'd0, 8'h12, 8'h34, 8'h05);
    pulse_start();
    repeat (10) @(negedge clk);
    repeat (3) begin
      pulse_start();
      repeat (7) @(negedge clk);
    end
    set_in(2'd3, 8'h59, 8'h07, 8'h10);
    wait_done(200);
    chk_line("IDLE 12:34 R05  ");
    @(negedge clk);
    chk("pend_idle_busy", bus.busy, 1'b0);
    @(negedge clk);
    chk("pend_load_busy", bus.busy, 1'b1);
    wait_done(200);
    chk_line("DONE 59:07 R10  ");
    repeat (30) @(negedge clk);
    chk("pend_frames", n_done - d0, 2);

    // Input changes mid-frame are ignored until the next frame.
    set_in(2'd1, 8'h45, 8'h00, 8'h99);
    pulse_start();
    wait_col(4'd4, 1'b0, 200);
    set_in(2'd2, 8'h01, 8'h02, 8'h03);
    wait_done(200);
    chk_line("WORK 45:00 R99  ");
    pulse_start();
    wait_done(200);
    chk_line("REST 01:02 R03  ");

    // Reset in the middle of slot 7 aborts the frame and drops the pending request.
    repeat (5) @(negedge clk);
    set_in(2'd3, 8'h22, 8'h33, 8'h44);
    pulse_start();
    wait_col(4'd3, 1'b0, 200);
    pulse_start();
    wait_col(4'd7, 1'b1, 200);
    d0 = n_done;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_we", bus.char_we, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    repeat (30) @(negedge clk);
    chk("rst_no_done", n_done - d0, 0);
    chk("rst_no_pending", bus.busy, 1'b0);
    set_in(2'd0, 8'h00, 8'h09, 8'h01);
    pulse_start();
    wait_done(200);
    chk_line("IDLE 00:09 R01  ");

    // Randomized requests, including held start and pulses landing at any point.
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      set_in(2'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      bus.start = 1'b1;
      repeat ($urandom_range(1, 3 * GAP)) @(negedge clk);
      bus.start = 1'b0;
      repeat ($urandom_range(0, 120)) @(negedge clk);
    end
    bus.start = 1'b0;
    repeat (3 * FRAME_LEN) @(negedge clk);
    chk("final_idle", bus.busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
